bcd_stopwatch_counter: RTL and testbench
========================================

Name: bcd_stopwatch_counter

Overview:
Sequential time source that produces the 32-bit packed-BCD time word consumed by the team's eight-digit seven-segment display driver. It counts HH:MM:SS.cc in hundredths of a second from a prescaled system clock. It supports start/stop/clear control and a ready/valid preset load. It sits between the control FSM and the display driver; its time_bcd output wires directly to the driver's time_in_bcd input.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
TICK_HZ, 100, count rate in Hz; DIV = CLK_HZ/TICK_HZ; integer ratio >= 2 required (elaboration error otherwise)

Ports:
clk  in  1  system clock, single domain
rst  in  1  reset, synchronous, active-high
start  in  1  pulse: enter RUN
stop  in  1  pulse: enter IDLE (hold count)
clear  in  1  pulse: zero all digits and prescaler; run state unchanged
load_valid  in  1  preset request
load_bcd  in  32  preset value, same packing as time_bcd
load_ready  out  1  high when a load is accepted this cycle if valid (= IDLE state)
load_err  out  1  1-cycle pulse: load rejected (invalid digit)
time_bcd  out  32  [31:28] hour tens .. [23:20] min tens .. [15:12] sec tens .. [7:4] cs tens, [3:0] cs units
running  out  1  high in RUN
rollover  out  1  1-cycle pulse on 23:59:59.99 -> 00:00:00.00

Behaviour:
- Reset, sync active-high: time_bcd=32'h0, running=0, load_ready=1, load_err=0, rollover=0, prescaler=0, state IDLE.
- FSM states:
  - IDLE -> RUN on start.
  - RUN -> IDLE on stop.
  - start and stop in the same cycle: stop wins.
- Per-cycle priority: rst > clear > load > stop > start.
- Prescaler:
  - Counts 0..DIV-1 only in RUN and holds in IDLE.
  - tick asserts on the cycle the prescaler equals DIV-1, then the prescaler wraps to 0.
  - Prescaler is zeroed by rst, clear and an accepted load.
- Timing: time_bcd is registered and updates on the clock edge after the tick cycle. From start with prescaler=0, the first increment is visible DIV cycles later.
- Digit limits, with carry ripple in the same cycle:
  - cs units 0-9, cs tens 0-9
  - s units 0-9, s tens 0-5
  - m units 0-9, m tens 0-5
  - hours 00-23: at 23 -> 00 the carry out asserts rollover.
- Rollover: the pulse coincides with the time_bcd update to 32'h0, and counting continues.
- Load handshake: accepted when load_valid && load_ready.
  - Validity: all nibbles <= 9, s tens <= 5, m tens <= 5, hours <= 23.
  - Valid load: time_bcd = load_bcd next cycle.
  - Invalid load: time_bcd unchanged and load_err pulses one cycle.
  - load_valid in RUN: ignored, with no err.
- clear in RUN: time_bcd = 0 next cycle and counting continues from prescaler 0.
- Reset mid-run: state returns to IDLE and all values go to reset values.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- Defined: time_bcd nibbles from [31:28] downward that are leading zeros are output as 4'hF; the display driver shows these as blank. Blanking stops at the first nonzero digit, and nibbles [7:0] are never blanked.
  - Blanking is registered with the same latency as the digits.
  - Internal counters, load validation and rollover are unaffected.
- Undefined: raw BCD is always output.

Decomposition:
- Package bcd_time_pkg holds:
  - digit index localparams (CS_U .. HR_T)
  - per-digit limit constants
  - the BLANK_NIBBLE = 4'hF constant
  - the typedef for the 8x4-bit digit array
  - the load-validity function
- Sub-module bcd_digit_counter:
  - Parameter LIMIT; inputs clk/rst/clr/load/load_val/inc; outputs value[3:0] and carry.
  - Instantiated for the six minute/second/centisecond digits.
  - The hour pair uses dedicated 00-23 logic in the top module.

Test Plan:
All tests use CLK_HZ=1000, TICK_HZ=100, so DIV=10.
- Reset then start, run 120 cycles -> time_bcd=32'h00000012, running=1, no rollover.
- Preset load 32'h23595995 in IDLE, start, run 50 cycles -> time_bcd=32'h00000000 after the 5th tick, rollover pulses exactly once on that update.
- Load 32'h00600000 (s tens=6) in IDLE -> load_err pulses one cycle and time_bcd is unchanged. Load asserted in RUN -> ignored, load_ready=0, no err.
- Count to 32'h00000009, then pulse stop for 100 cycles -> value held. Then start, wait 10 cycles -> 32'h00000010, with correct cs-tens carry.
- Apply start+stop+clear in the same cycle during RUN -> time_bcd=0, running=0. Assert rst mid-run -> all outputs return to reset values next cycle.
- With LEADING_ZERO_BLANK_EN defined, load 32'h00010507 -> time_bcd=32'hFFF10507. Load 32'h0 -> time_bcd=32'hFFFFFF00.

Source files
------------

// File: rtl/bcd_time_pkg.sv
// Shared definitions for the BCD stopwatch:
// - digit indices and per-digit limits
// - the blank-nibble code
// - the packed digit array type
// - the preset validity check
package bcd_time_pkg;

  // Digit positions inside the packed time word (nibble index)
  localparam int CS_U = 0;
  localparam int CS_T = 1;
  localparam int S_U  = 2;
  localparam int S_T  = 3;
  localparam int M_U  = 4;
  localparam int M_T  = 5;
  localparam int HR_U = 6;
  localparam int HR_T = 7;

  // Largest legal value per digit. Hour units may reach 9, except when
  // hour tens is 2, where the ceiling is HR_U_MAX_AT_TOP.
  localparam logic [3:0] LIM_CS_U = 4'd9;
  localparam logic [3:0] LIM_CS_T = 4'd9;
  localparam logic [3:0] LIM_S_U  = 4'd9;
  localparam logic [3:0] LIM_S_T  = 4'd5;
  localparam logic [3:0] LIM_M_U  = 4'd9;
  localparam logic [3:0] LIM_M_T  = 4'd5;
  localparam logic [3:0] LIM_HR_U = 4'd9;
  localparam logic [3:0] LIM_HR_T = 4'd2;
  localparam logic [3:0] HR_U_MAX_AT_TOP = 4'd3;

  localparam logic [7:0][3:0] DIGIT_LIMIT = {LIM_HR_T, LIM_HR_U, LIM_M_T, LIM_M_U,
                                             LIM_S_T, LIM_S_U, LIM_CS_T, LIM_CS_U};

  // Nibble code the display driver renders as an unlit digit
  localparam logic [3:0] BLANK_NIBBLE = 4'hF;

  typedef logic [7:0][3:0] digits_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } run_state_t;

  // True when every digit is within its limit and the hour pair is <= 23
  function automatic logic bcd_time_valid(input digits_t d);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (d[i] > DIGIT_LIMIT[i]) ok = 1'b0;
    end
    if ((d[HR_T] == LIM_HR_T) && (d[HR_U] > HR_U_MAX_AT_TOP)) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..LIMIT. It has clear, load and increment
// controls, in that priority order. carry is combinational: it is high when
// an increment arrives at LIMIT, so the next digit steps in the same cycle.
module bcd_digit_counter
  import bcd_time_pkg::*;
#(
  parameter logic [3:0] LIMIT = 4'd9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       inc,
  output logic [3:0] value,
  output logic       carry
);

  logic [3:0] value_reg;

  assign carry = inc && (value_reg == LIMIT);
  assign value = value_reg;

  // Digit register: clear/reset, then preset, then increment with wrap
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value_reg <= 4'd0;
    end else if (load) begin
      value_reg <= load_val;
    end else if (inc) begin
      value_reg <= carry ? 4'd0 : value_reg + 4'd1;
    end
  end

endmodule

// File: rtl/bcd_stopwatch_counter.sv
// HH:MM:SS.cc stopwatch producing a packed-BCD time word for the display.
// The design has:
// - a prescaled hundredths tick
// - start/stop/clear control
// - a ready/valid preset load
// Optional build macro LEADING_ZERO_BLANK_EN: leading zero digits from the
// hour tens down to the second units are output as BLANK_NIBBLE.
module bcd_stopwatch_counter
  import bcd_time_pkg::*;
#(
  parameter int CLK_HZ  = 50000000,
  parameter int TICK_HZ = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        load_valid,
  input  logic [31:0] load_bcd,
  output logic        load_ready,
  output logic        load_err,
  output logic [31:0] time_bcd,
  output logic        running,
  output logic        rollover
);

  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  generate
    if ((DIV < 2) || ((CLK_HZ % TICK_HZ) != 0)) begin : g_bad_div
      $error("bcd_stopwatch_counter: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
  endgenerate

  run_state_t  state_reg, state_next;
  logic [PW-1:0] presc_reg, presc_next;
  logic [3:0]  hr_t_reg, hr_u_reg;
  logic        rollover_reg, load_err_reg;
  logic        tick, count_en, load_take, load_ok, load_apply, hr_inc, hr_at_top;
  digits_t     digit_vec;

  // Run state register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next run state: stop beats start, independent of clear/load
  always_comb begin
    state_next = state_reg;
    if (stop)       state_next = ST_IDLE;
    else if (start) state_next = ST_RUN;
  end

  // Outputs decoded from the run state
  always_comb begin
    running    = (state_reg == ST_RUN);
    load_ready = (state_reg == ST_IDLE);
  end

  // A load is only taken in IDLE and only when clear is not also asking
  assign load_take  = load_valid && load_ready && !clear;
  assign load_ok    = bcd_time_valid(load_bcd);
  assign load_apply = load_take && load_ok;
  assign tick       = running && (presc_reg == PRESC_LAST);
  assign count_en   = tick && !clear;

  // Prescaler next value: zeroed by clear/preset, advances only while running
  always_comb begin
    presc_next = presc_reg;
    if (clear || load_apply) presc_next = '0;
    else if (running)        presc_next = tick ? '0 : presc_reg + 1'b1;
  end

  // Prescaler register
  always_ff @(posedge clk) begin
    if (rst) presc_reg <= '0;
    else     presc_reg <= presc_next;
  end

  // Centisecond, second and minute digits as a ripple-carry chain
  generate
    for (genvar gi = CS_U; gi <= M_T; gi++) begin : g_digit
      logic       inc_in;
      logic       carry_out;
      logic [3:0] value;

      if (gi == CS_U) begin : g_first
        assign inc_in = count_en;
      end else begin : g_chain
        assign inc_in = g_digit[gi-1].carry_out;
      end

      bcd_digit_counter #(
        .LIMIT(DIGIT_LIMIT[gi])
      ) u_digit (
        .clk     (clk),
        .rst     (rst),
        .clr     (clear),
        .load    (load_apply),
        .load_val(load_bcd[gi*4 +: 4]),
        .inc     (inc_in),
        .value   (value),
        .carry   (carry_out)
      );

      assign digit_vec[gi] = value;
    end
  endgenerate

  assign hr_inc    = g_digit[M_T].carry_out;
  assign hr_at_top = (hr_t_reg == LIM_HR_T) && (hr_u_reg == HR_U_MAX_AT_TOP);

  // Hour pair 00..23, wrapping to 00 and flagging the day rollover
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      hr_t_reg     <= 4'd0;
      hr_u_reg     <= 4'd0;
      rollover_reg <= 1'b0;
    end else begin
      rollover_reg <= 1'b0;
      if (load_apply) begin
        hr_t_reg <= load_bcd[HR_T*4 +: 4];
        hr_u_reg <= load_bcd[HR_U*4 +: 4];
      end else if (hr_inc) begin
        if (hr_at_top) begin
          hr_t_reg     <= 4'd0;
          hr_u_reg     <= 4'd0;
          rollover_reg <= 1'b1;
        end else if (hr_u_reg == LIM_HR_U) begin
          hr_u_reg <= 4'd0;
          hr_t_reg <= hr_t_reg + 4'd1;
        end else begin
          hr_u_reg <= hr_u_reg + 4'd1;
        end
      end
    end
  end

  // One-cycle reject flag for a preset containing an out-of-range digit
  always_ff @(posedge clk) begin
    if (rst) load_err_reg <= 1'b0;
    else     load_err_reg <= load_take && !load_ok;
  end

  assign digit_vec[HR_U] = hr_u_reg;
  assign digit_vec[HR_T] = hr_t_reg;
  assign rollover        = rollover_reg;
  assign load_err        = load_err_reg;

`ifdef LEADING_ZERO_BLANK_EN
  digits_t disp_vec;
  logic    leading;

  // Blank zero digits from the top until the first nonzero; the two
  // centisecond digits always show. The digits are already registered, so
  // the blanked word changes on the same edge as the digits.
  always_comb begin
    disp_vec = digit_vec;
    leading  = 1'b1;
    for (int i = HR_T; i >= S_U; i--) begin
      if (leading && (digit_vec[i] == 4'd0)) disp_vec[i] = BLANK_NIBBLE;
      else                                   leading     = 1'b0;
    end
  end

  assign time_bcd = disp_vec;
`else
  assign time_bcd = digit_vec;
`endif

endmodule

// File: tb/tb_bcd_stopwatch_counter.sv
// Bench for bcd_stopwatch_counter (CLK_HZ=1000, TICK_HZ=100 -> DIV=10).
// The time model keeps elapsed centiseconds as one integer and converts
// that integer to BCD for comparison with time_bcd.
module tb_bcd_stopwatch_counter;

  localparam int CLK_HZ = 1000;
  localparam int TICK_HZ = 100;
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int DAY_CS = 24 * 60 * 60 * 100;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic [31:0] L_ZERO  = 32'hFFFFFF00;
  localparam logic [31:0] L_12    = 32'hFFFFFF12;
  localparam logic [31:0] L_09    = 32'hFFFFFF09;
  localparam logic [31:0] L_10    = 32'hFFFFFF10;
  localparam logic [31:0] L_02    = 32'hFFFFFF02;
  localparam logic [31:0] L_1234  = 32'hFFFF1234;
  localparam logic [31:0] L_10507 = 32'hFFF10507;
`else
  localparam logic [31:0] L_ZERO  = 32'h00000000;
  localparam logic [31:0] L_12    = 32'h00000012;
  localparam logic [31:0] L_09    = 32'h00000009;
  localparam logic [31:0] L_10    = 32'h00000010;
  localparam logic [31:0] L_02    = 32'h00000002;
  localparam logic [31:0] L_1234  = 32'h00001234;
  localparam logic [31:0] L_10507 = 32'h00010507;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear = 1'b0;
  logic        load_valid = 1'b0;
  logic [31:0] load_bcd = 32'h0;
  logic        load_ready, load_err, running, rollover;
  logic [31:0] time_bcd;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  bcd_stopwatch_counter #(
    .CLK_HZ (CLK_HZ),
    .TICK_HZ(TICK_HZ)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .stop      (stop),
    .clear     (clear),
    .load_valid(load_valid),
    .load_bcd  (load_bcd),
    .load_ready(load_ready),
    .load_err  (load_err),
    .time_bcd  (time_bcd),
    .running   (running),
    .rollover  (rollover)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic run;
    int   presc;
    int   cs;
    logic err;
    logic roll;
  } mstate_t;

  mstate_t m = '0;

  function automatic int nib(input logic [31:0] w, input int i);
    logic [31:0] t;
    t = (w >> (4 * i)) & 32'hF;
    return int'(t);
  endfunction

  function automatic bit model_valid(input logic [31:0] w);
    for (int i = 0; i < 8; i++) if (nib(w, i) > 9) return 1'b0;
    if (nib(w, 3) > 5 || nib(w, 5) > 5) return 1'b0;
    return (nib(w, 7) * 10 + nib(w, 6)) <= 23;
  endfunction

  function automatic int bcd_to_cs(input logic [31:0] w);
    int h, mi, s, c;
    h  = nib(w, 7) * 10 + nib(w, 6);
    mi = nib(w, 5) * 10 + nib(w, 4);
    s  = nib(w, 3) * 10 + nib(w, 2);
    c  = nib(w, 1) * 10 + nib(w, 0);
    return ((h * 60 + mi) * 60 + s) * 100 + c;
  endfunction

  function automatic logic [31:0] cs_to_bcd(input int cs);
    int h, mi, s, c;
    logic [31:0] r;
    logic [31:0] f;
    h  = cs / 360000;
    mi = (cs / 6000) % 60;
    s  = (cs / 100) % 60;
    c  = cs % 100;
    r = 32'((h / 10) << 28 | (h % 10) << 24 | (mi / 10) << 20 | (mi % 10) << 16 |
            (s / 10) << 12 | (s % 10) << 8 | (c / 10) << 4 | (c % 10));
`ifdef LEADING_ZERO_BLANK_EN
    for (int i = 7; i >= 2; i--) begin
      if (nib(r, i) != 0) break;
      f = 32'hF << (4 * i);
      r = r | f;
    end
`else
    f = 32'h0;
    r = r | f;
`endif
    return r;
  endfunction

  function automatic mstate_t model_next(input mstate_t s, input logic r, input logic st,
                                         input logic sp, input logic cl, input logic lv,
                                         input logic [31:0] lb);
    mstate_t n;
    n = s;
    n.err = 1'b0;
    n.roll = 1'b0;
    if (r) begin
      n = '0;
      return n;
    end
    if (sp)      n.run = 1'b0;
    else if (st) n.run = 1'b1;
    if (cl) begin
      n.cs = 0;
      n.presc = 0;
    end else if (!s.run) begin
      if (lv) begin
        if (model_valid(lb)) begin
          n.cs = bcd_to_cs(lb);
          n.presc = 0;
        end else begin
          n.err = 1'b1;
        end
      end
    end else if (s.presc == DIV - 1) begin
      n.presc = 0;
      n.cs = s.cs + 1;
      if (n.cs == DAY_CS) begin
        n.cs = 0;
        n.roll = 1'b1;
      end
    end else begin
      n.presc = s.presc + 1;
    end
    return n;
  endfunction

  always @(posedge clk) m <= model_next(m, rst, start, stop, clear, load_valid, load_bcd);

  // ---------------- checking ----------------
  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Every cycle after reset, compare all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [35:0] exp_v, act_v;
      exp_v = {cs_to_bcd(m.cs), m.run, !m.run, m.err, m.roll};
      act_v = {time_bcd, running, load_ready, load_err, rollover};
      n_checks++;
      if (act_v === exp_v) n_pass++;
      else $display("FAIL model_cmp @%0t: got time=%08h run/rdy/err/roll=%b, expected time=%08h run/rdy/err/roll=%b",
                    $time, act_v[35:4], act_v[3:0], exp_v[35:4], exp_v[3:0]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    $display("[%0t] start", $time);
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    $display("[%0t] stop", $time);
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic drive_load(input logic [31:0] v);
    $display("[%0t] load 0x%08h", $time, v);
    load_bcd = v;
    load_valid = 1'b1;
    cyc(1);
    load_valid = 1'b0;
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    chk_en = 1'b1;
    lit("reset_time", time_bcd, L_ZERO);
    lit("reset_running", {31'b0, running}, 32'd0);
    lit("reset_ready", {31'b0, load_ready}, 32'd1);

    // Free run for 120 cycles: twelve hundredths
    pulse_start();
    cyc(120);
    lit("run120_time", time_bcd, L_12);
    lit("run120_running", {31'b0, running}, 32'd1);

    // Preset near midnight, roll over on the fifth tick
    pulse_stop();
    drive_load(32'h23595995);
    lit("preset_time", time_bcd, 32'h23595995);
    pulse_start();
    cyc(49);
    lit("pre_roll_time", time_bcd, 32'h23595999);
    lit("pre_roll_flag", {31'b0, rollover}, 32'd0);
    cyc(1);
    lit("roll_time", time_bcd, L_ZERO);
    lit("roll_flag", {31'b0, rollover}, 32'd1);
    cyc(1);
    lit("post_roll_flag", {31'b0, rollover}, 32'd0);

    // Invalid preset rejected; preset ignored while running
    pulse_stop();
    drive_load(32'h00001234);
    lit("load_1234", time_bcd, L_1234);
    drive_load(32'h00600000);
    lit("bad_load_err", {31'b0, load_err}, 32'd1);
    lit("bad_load_time", time_bcd, L_1234);
    cyc(1);
    lit("bad_load_err_end", {31'b0, load_err}, 32'd0);
    pulse_start();
    $display("[%0t] load 0x00000500 while running", $time);
    load_bcd = 32'h00000500;
    load_valid = 1'b1;
    lit("run_ready_low", {31'b0, load_ready}, 32'd0);
    cyc(1);
    load_valid = 1'b0;
    lit("run_load_no_err", {31'b0, load_err}, 32'd0);
    lit("run_load_ignored", time_bcd, L_1234);

    // Hold at 09 while stopped, then carry into cs tens
    pulse_stop();
    drive_load(32'h0);
    pulse_start();
    cyc(90);
    lit("count_09", time_bcd, L_09);
    pulse_stop();
    cyc(100);
    lit("hold_09", time_bcd, L_09);
    lit("hold_running", {31'b0, running}, 32'd0);
    pulse_start();
    cyc(10);
    lit("carry_10", time_bcd, L_10);

    // start+stop+clear together while running
    $display("[%0t] start+stop+clear", $time);
    start = 1'b1;
    stop = 1'b1;
    clear = 1'b1;
    cyc(1);
    start = 1'b0;
    stop = 1'b0;
    clear = 1'b0;
    lit("ssc_time", time_bcd, L_ZERO);
    lit("ssc_running", {31'b0, running}, 32'd0);

    // Reset in the middle of a run
    pulse_start();
    cyc(25);
    lit("pre_rst_time", time_bcd, L_02);
    $display("[%0t] reset", $time);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    lit("mid_rst_time", time_bcd, L_ZERO);
    lit("mid_rst_running", {31'b0, running}, 32'd0);
    lit("mid_rst_ready", {31'b0, load_ready}, 32'd1);

    // Boundary presets and blanking patterns
    drive_load(32'h24000000);
    lit("hour24_err", {31'b0, load_err}, 32'd1);
    lit("hour24_time", time_bcd, L_ZERO);
    drive_load(32'h23595999);
    lit("max_load", time_bcd, 32'h23595999);
    drive_load(32'h00010507);
    lit("load_10507", time_bcd, L_10507);
    drive_load(32'h0);
    lit("load_zero", time_bcd, L_ZERO);

    cyc(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
